// File: rtl/therm_adc_sampler.sv
// Serial ADC front end for the thermistor path: frames an 8-bit SPI-style ADC on a
// fixed period, captures each conversion and box-car averages 2^AVG_LOG2 samples.
module therm_adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int AVG_LOG2      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_sdo,
  output logic [7:0] v_therm,
  output logic       v_valid,
  output logic       busy
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_ACCUM
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_period;
  logic [DW-1:0] r_div;
  logic [3:0]    r_bit;
  logic [7:0]    r_sample;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_drop;

  logic          w_start;
  logic          w_div_end;
  logic          w_in_window;
  logic [AW-1:0] w_sum;

  assign w_start     = enable && (r_period == '0) && (r_state == S_IDLE);
  assign w_div_end   = (r_div == DIV_LAST);
  assign w_in_window = (r_bit >= 4'd3) && (r_bit <= 4'd10);
  assign w_sum       = r_acc + AW'(r_sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (!enable) begin
      r_period <= '0;
    end else if (r_period == PER_LAST) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_sample <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_drop   <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      v_therm  <= '0;
      v_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      v_valid <= 1'b0;
      // Remember an enable drop anywhere in the frame so the window is discarded at ACCUM.
      if (!enable && r_state != S_IDLE) r_drop <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_CS_SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            r_div    <= '0;
          end
        end
        S_CS_SETUP: begin
          if (w_div_end) begin
            r_state  <= S_SHIFT;
            adc_sclk <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!adc_sclk) begin
              // Rising SCLK edge: the ADC has held this bit for a full low half.
              adc_sclk <= 1'b1;
              if (w_in_window) r_sample <= {r_sample[6:0], adc_sdo};
            end else if (r_bit == 4'd15) begin
              r_state <= S_CS_HOLD;
            end else begin
              r_bit    <= r_bit + 1'b1;
              adc_sclk <= 1'b0;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_CS_HOLD: begin
          if (w_div_end) begin
            r_state  <= S_ACCUM;
            adc_cs_n <= 1'b1;
            r_div    <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_ACCUM: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          r_drop  <= 1'b0;
          if (r_drop || !enable) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            v_therm <= w_sum[AW-1:AVG_LOG2];
            v_valid <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_therm_adc_sampler.sv
// Directed bench: dut0 (no averaging) checks frame shape, dut1 (4-sample average)
// checks averaging, extremes, enable drop and asynchronous reset.
module tb_therm_adc_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic cs_n0, cs_n1, sclk0, sclk1, valid0, valid1, busy0, busy1;
  logic sdo0 = 1'b1, sdo1 = 1'b1;
  logic [7:0] vt0, vt1;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  therm_adc_sampler #(.CLK_DIV(2), .AVG_LOG2(0), .SAMPLE_PERIOD(100)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .adc_cs_n(cs_n0), .adc_sclk(sclk0),
    .adc_sdo(sdo0), .v_therm(vt0), .v_valid(valid0), .busy(busy0)
  );
  therm_adc_sampler #(.CLK_DIV(2), .AVG_LOG2(2), .SAMPLE_PERIOD(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .adc_cs_n(cs_n1), .adc_sclk(sclk1),
    .adc_sdo(sdo1), .v_therm(vt1), .v_valid(valid1), .busy(busy1)
  );

  // ADC models: ignored frame bits are driven high so a misaligned capture shows up.
  logic [7:0]  q0[$], q1[$];
  logic [15:0] w0 = '1, w1 = '1;

  function automatic logic [15:0] adc_word(input logic [7:0] code);
    return {3'b111, code, 5'b11111};
  endfunction

  always @(negedge cs_n0) begin
    if (q0.size() > 0) w0 = adc_word(q0.pop_front());
    else w0 = adc_word(8'h00);
  end
  always @(negedge sclk0) if (!cs_n0) begin
    sdo0 = w0[15];
    w0 = {w0[14:0], 1'b1};
  end
  always @(negedge cs_n1) begin
    if (q1.size() > 0) w1 = adc_word(q1.pop_front());
    else w1 = adc_word(8'h00);
  end
  always @(negedge sclk1) if (!cs_n1) begin
    sdo1 = w1[15];
    w1 = {w1[14:0], 1'b1};
  end

  wire [1:0]  w_cs    = {cs_n1, cs_n0};
  wire [1:0]  w_sclk  = {sclk1, sclk0};
  wire [1:0]  w_busy  = {busy1, busy0};
  wire [1:0]  w_valid = {valid1, valid0};
  wire [15:0] w_vt    = {vt1, vt0};

  // Frame monitors, sampled on the falling clk edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    int starts = 0, ends = 0, start_cyc = 0, low_cnt = 0, rise_cnt = 0, run = 0;
    int last_low = 0, last_rise = 0, bad_phase = 0, start_busy_err = 0, valid_cnt = 0;
    int vcyc [16];
    logic [7:0] vlog [16];
    logic in_frame = 1'b0, prev_sclk = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        in_frame = 1'b0;
        prev_sclk = 1'b1;
        prev_busy = 1'b0;
      end else begin
        if (!w_cs[gi]) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            starts++;
            start_cyc = cyc;
            low_cnt = 0;
            rise_cnt = 0;
            run = 0;
            if (prev_busy) start_busy_err++;
          end
          low_cnt++;
          if (low_cnt > 1 && w_sclk[gi] != prev_sclk) begin
            if (run != 2) bad_phase++;
            if (w_sclk[gi]) rise_cnt++;
            run = 0;
          end
          run++;
        end else if (in_frame) begin
          in_frame = 1'b0;
          ends++;
          last_low = low_cnt;
          last_rise = rise_cnt;
        end
        if (w_valid[gi]) begin
          vlog[valid_cnt % 16] = w_vt[gi*8 +: 8];
          vcyc[valid_cnt % 16] = cyc;
          $display("dut%0d valid #%0d v_therm=0x%02h cycle=%0d", gi, valid_cnt, w_vt[gi*8 +: 8], cyc);
          valid_cnt++;
        end
        prev_sclk = w_sclk[gi];
        prev_busy = w_busy[gi];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int e0;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n1, 1'b1);
    chk("rst_sclk", sclk1, 1'b1);
    chk("rst_busy", busy1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cs_n", {cs_n1, cs_n0}, 2'b11);
      chk("idle_sclk", {sclk1, sclk0}, 2'b11);
      chk("idle_valid", {valid1, valid0}, 2'b00);
      chk("idle_busy", {busy1, busy0}, 2'b00);
      chk("idle_vtherm", {vt1, vt0}, 16'h0000);
    end

    // Single frame shape, no averaging
    q0.push_back(8'hA5);
    en0 = 1'b1;
    for (int i = 0; i < 200 && g_mon[0].valid_cnt == 0; i++) @(negedge clk);
    en0 = 1'b0;
    chk("frame_valid_count", g_mon[0].valid_cnt, 1);
    chk("frame_cs_low", g_mon[0].last_low, 68);
    chk("frame_sclk_rises", g_mon[0].last_rise, 16);
    chk("frame_latency", g_mon[0].vcyc[0] - g_mon[0].start_cyc, 69);
    chk("frame_vtherm", g_mon[0].vlog[0], 8'hA5);

    // Averaging followed by the two extremes
    q1.push_back(8'd10); q1.push_back(8'd11); q1.push_back(8'd12); q1.push_back(8'd14);
    for (int i = 0; i < 4; i++) q1.push_back(8'hFF);
    for (int i = 0; i < 4; i++) q1.push_back(8'h00);
    en1 = 1'b1;
    for (int i = 0; i < 600 && g_mon[1].valid_cnt == 0; i++) @(negedge clk);
    chk("avg_first_valid_seen", g_mon[1].valid_cnt, 1);
    chk("avg_frames_per_valid", g_mon[1].starts, 4);
    chk("avg_latency", g_mon[1].vcyc[0] - g_mon[1].start_cyc, 69);
    chk("avg_vtherm", g_mon[1].vlog[0], 8'd11);
    for (int i = 0; i < 1000 && g_mon[1].valid_cnt < 3; i++) @(negedge clk);
    chk("ext_valid_count", g_mon[1].valid_cnt, 3);
    chk("ext_ff", g_mon[1].vlog[1], 8'hFF);
    chk("ext_00", g_mon[1].vlog[2], 8'h00);
    chk("out_interval", g_mon[1].vcyc[1] - g_mon[1].vcyc[0], 400);

    // Enable drop in SHIFT of the 2nd frame of a window
    for (int i = 0; i < 300 && g_mon[1].starts < 14; i++) @(negedge clk);
    chk("drop_frame_started", g_mon[1].starts, 14);
    repeat (20) @(negedge clk);
    en1 = 1'b0;
    for (int i = 0; i < 100 && g_mon[1].ends < 14; i++) @(negedge clk);
    chk("drop_frame_done", g_mon[1].ends, 14);
    chk("drop_cs_low", g_mon[1].last_low, 68);
    chk("drop_sclk_rises", g_mon[1].last_rise, 16);
    repeat (120) @(negedge clk);
    chk("drop_no_valid", g_mon[1].valid_cnt, 3);
    chk("drop_idle_busy", busy1, 1'b0);
    q1.delete();
    q1.push_back(8'd20); q1.push_back(8'd21); q1.push_back(8'd22); q1.push_back(8'd23);
    s0 = g_mon[1].starts;
    en1 = 1'b1;
    for (int i = 0; i < 600 && g_mon[1].valid_cnt < 4; i++) @(negedge clk);
    chk("reen_valid_seen", g_mon[1].valid_cnt, 4);
    chk("reen_fresh_frames", g_mon[1].starts - s0, 4);
    chk("reen_vtherm", g_mon[1].vlog[3], 8'd21);

    // Asynchronous reset in SHIFT
    s0 = g_mon[1].starts;
    for (int i = 0; i < 200 && g_mon[1].starts == s0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pre_rst_in_frame", cs_n1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", cs_n1, 1'b1);
    chk("arst_sclk", sclk1, 1'b1);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_vtherm", vt1, 8'h00);
    q1.delete();
    q1.push_back(8'h40); q1.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h43);
    repeat (2) @(negedge clk);
    e0 = g_mon[1].ends;
    rst_n = 1'b1;
    for (int i = 0; i < 200 && g_mon[1].ends == e0; i++) @(negedge clk);
    chk("post_rst_frame_done", g_mon[1].ends - e0, 1);
    chk("post_rst_cs_low", g_mon[1].last_low, 68);
    chk("post_rst_sclk_rises", g_mon[1].last_rise, 16);
    for (int i = 0; i < 600 && g_mon[1].valid_cnt < 5; i++) @(negedge clk);
    chk("post_rst_valid_seen", g_mon[1].valid_cnt, 5);
    chk("post_rst_vtherm", g_mon[1].vlog[4], 8'h41);

    chk("sclk_phase_dut0", g_mon[0].bad_phase, 0);
    chk("sclk_phase_dut1", g_mon[1].bad_phase, 0);
    chk("start_while_busy", g_mon[0].start_busy_err + g_mon[1].start_busy_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/therm_adc_sampler.md
# therm_adc_sampler

Front-end stage of the thermistor path: drives an external 8-bit serial ADC (16-SCLK frame, ADC081S021-style) on a fixed sample period, captures each 8-bit conversion, and box-car averages 2^AVG_LOG2 samples. The averaged code is presented as `v_therm[7:0]` with a one-cycle `v_valid` strobe. It feeds the voltage-to-temperature conversion stage directly.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥1.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per output; range 0..4.
- `SAMPLE_PERIOD`, 1000: `clk` cycles between conversion starts; must be ≥ 34*CLK_DIV+2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run sampling while high.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles high.
- `adc_sdo`  in  1  ADC serial data, MSB first, driven by the ADC on SCLK falling edges.
- `v_therm`  out  8  averaged ADC code; holds its value between updates.
- `v_valid`  out  1  one-cycle pulse when `v_therm` updates.
- `busy`  out  1  high while a frame is in progress (`adc_cs_n` low or ACCUM).

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `v_therm`=0, `v_valid`=0, `busy`=0. Accumulator, sample count, period counter, and FSM (IDLE) are cleared. Reset is asynchronous at any point, including mid-frame, and returns the outputs to these values immediately.
- Period counter: while `enable`=1 it counts 0..SAMPLE_PERIOD-1 and wraps. A frame starts when the count is 0. While `enable`=0 the counter is held at 0.
- FSM states:
  - IDLE: leave when the start condition is met; go to CS_SETUP.
  - CS_SETUP: `adc_cs_n`=0, `adc_sclk`=1, for CLK_DIV cycles.
  - SHIFT: 16 bits. Each bit is a low half (`adc_sclk`=0, CLK_DIV cycles) followed by a high half (`adc_sclk`=1, CLK_DIV cycles).
  - CS_HOLD: `adc_sclk`=1, `adc_cs_n`=0, for CLK_DIV cycles.
  - ACCUM: `adc_cs_n`=1, for 1 cycle; then go to IDLE.
- Capture: `adc_sdo` is sampled on the `clk` edge that drives `adc_sclk` 0→1, once per bit, for bit indices 0..15. Bits 3..10 form the sample, with bit 3 as the MSB. Bits 0..2 and 11..15 are ignored and are not checked.
- Accumulate: in ACCUM, `acc += sample`. The accumulator is 8+AVG_LOG2 bits wide and cannot overflow.
  - When the 2^AVG_LOG2-th sample is added, `v_therm` ← (acc+sample) >> AVG_LOG2 (truncating), `v_valid` pulses, and acc and the count clear.
  - With AVG_LOG2=0, every sample is output unchanged.
- `enable` falling mid-frame: the current frame completes, including ACCUM. After it, the partial accumulation and count are discarded and the block goes to IDLE. `v_therm` holds its value.
- `enable` rising: the first frame starts on the next cycle (period count is 0).

## Timing
- A frame lasts 34*CLK_DIV cycles with `adc_cs_n` low, plus 1 ACCUM cycle.
- Latency from a frame start (entering CS_SETUP) to `v_valid`: 34*CLK_DIV+1 cycles, on the last frame of an averaging window. `v_valid` is registered.
- Output rate: one `v_valid` every SAMPLE_PERIOD*2^AVG_LOG2 cycles in steady state.
- Start conditions and busy: by the parameter constraint, a start condition never occurs while `busy`=1. The bench must flag any such occurrence as an error.
- ADC setup timing: `adc_sclk` low phases and high phases are each exactly CLK_DIV cycles. The MSB is valid for ≥ CLK_DIV cycles before its capturing edge.

## Test plan
- Reset and idle: `rst_n`=0, then release with `enable`=0. Required: `adc_cs_n`=1, `adc_sclk`=1, `v_therm`=0, `v_valid`=0, `busy`=0 throughout.
- Single frame shape (CLK_DIV=2, AVG_LOG2=0): ADC model returns 0xA5. Required:
  - `adc_cs_n` low for 68 cycles.
  - exactly 16 SCLK rising edges.
  - `v_valid` 69 cycles after the start, with `v_therm`=0xA5.
- Averaging (AVG_LOG2=2, SAMPLE_PERIOD=100): ADC model returns 10, 11, 12, 14. Required: a single `v_valid` with `v_therm`=11 (47>>2), with no pulses on the intermediate frames.
- Extremes: four samples of 0xFF give `v_therm`=0xFF; four samples of 0x00 give 0x00. The accumulator does not wrap.
- Enable drop: deassert `enable` during the SHIFT state of the 2nd frame of a window. Required:
  - the frame completes.
  - no `v_valid`.
  - after re-enabling, the next `v_valid` comes after 4 fresh frames.
- Async reset mid-SHIFT: assert `rst_n`=0. Required: `adc_cs_n`, `adc_sclk`, and `busy` return to their reset values without a clock edge. After release, a clean frame occurs.
